mux9_rr_sel_arbiter: RTL and testbench
======================================

// Module: mux9_rr_sel_arbiter
// PURPOSE
//   Upstream select generator for the 9:1 16-bit data mux. Arbitrates round-robin among 9
//   packet sources and drives the mux select with the index of the granted source. Holds that
//   select for a whole packet, using a valid/ready handshake to the downstream consumer.
//   A beat-count watchdog releases a grant when a source never presents a last beat.
// PARAMETERS
//   NUM_SRC    9                      number of sources; sel value k selects source k (0=a .. 8=i)
//   SEL_W      4                      select width, >= $clog2(NUM_SRC)
//   MAX_BEATS  16                     max beats per packet before forced release (>=1)
//   CNT_W      $clog2(MAX_BEATS+1)    beat counter width
// PORTS
//   clk        in   1        single clock, all state on rising edge
//   rst_n      in   1        asynchronous active-low reset
//   req        in   NUM_SRC  req[k]=1: source k has a beat available
//   req_last   in   NUM_SRC  req_last[k]=1: current beat of source k is its last beat
//   out_ready  in   1        downstream accepts the beat this cycle
//   sel        out  SEL_W    mux select = index of granted/last-granted source
//   grant      out  NUM_SRC  one-hot grant; all-zero when idle
//   out_valid  out  1        beat valid on mux output (= busy & req[sel])
//   out_last   out  1        out_valid & req_last[sel]
//   timeout_err out 1        one-cycle pulse on watchdog release
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; sel=0; grant=0; out_valid=0; out_last=0;
//     timeout_err=0; ptr=0; beat_cnt=0. Reset mid-packet abandons the packet immediately.
//   State machine: IDLE -> BUSY -> IDLE only. No direct BUSY->BUSY handoff.
//   IDLE:
//     - If req != 0, pick the first set bit scanning ptr, ptr+1, ... mod NUM_SRC.
//     - Register the winner into sel and grant, then go to BUSY.
//     - Latency: req rises in cycle N -> grant/sel valid in cycle N+1.
//     - If req == 0, stay in IDLE. sel keeps its last value. grant=0.
//   BUSY:
//     - sel and grant are stable for the whole packet.
//     - Beat transfer = out_valid & out_ready. Each transfer increments beat_cnt.
//     - If req[sel] drops, out_valid=0. Grant is held and the cycle is not counted.
//     - Backpressure (out_ready=0): nothing changes and nothing is counted.
//     - Normal end: a transfer with req_last[sel]=1 ->
//         next cycle IDLE, grant=0, beat_cnt=0, ptr=(sel==NUM_SRC-1)?0:sel+1.
//     - Watchdog: a transfer with req_last[sel]=0 that makes beat_cnt reach MAX_BEATS ->
//         next cycle IDLE, timeout_err=1 for exactly that one cycle, ptr advances as above.
//     - If the watchdog beat also has req_last=1, treat it as a normal end (no timeout_err).
//   Guaranteed idle bubble: at least one cycle with grant=0 between packets.
//   Max wait for a continuously requesting source: 8 packets.
//   Requests to non-granted sources in BUSY are ignored. They are resampled in IDLE.
//   Out-of-range sel (>=NUM_SRC) is never produced.
//   Invariants: grant is one-hot or zero; grant[sel]=1 whenever busy.
// TESTING
//   1. Reset mid-packet: assert rst_n=0 asynchronously during BUSY ->
//      all outputs 0 that same cycle; after release, first grant goes to source 0 if req[0].
//   2. req=9'h001, req_last on 3rd beat, out_ready=1 ->
//      grant=9'h001/sel=0 one cycle later; out_valid for 3 cycles; out_last on 3rd; grant=0 next.
//   3. req=9'h1FF held, all single-beat packets ->
//      sel sequence 0,1,...,8,0 with one idle cycle between each.
//   4. Backpressure: out_ready=0 for 5 cycles mid-packet of source 2 ->
//      sel=2, grant=9'h004 stable; beat_cnt unchanged; packet then completes normally.
//   5. Watchdog: source 4 streams 16 beats with req_last=0, req[5] also set ->
//      timeout_err pulses 1 cycle after beat 16; next grant = source 5.
//   6. Wrap: source 8 completes, then req=9'h101 -> source 0 granted (ptr wrapped), not 8.

Source files
------------

// File: rtl/mux9_rr_sel_arbiter.sv
// mux9_rr_sel_arbiter
//   Select generator sitting in front of the 9:1 16-bit data mux. Nine packet
//   sources are arbitrated round-robin; the winner's index drives the mux select
//   and is held for the whole packet. Beats leave through a valid/ready handshake.
//   A beat-count watchdog forces the grant free when a source never signals a
//   last beat, and reports it with a one-cycle error pulse.
//
// Ports
//   clk           in   1        rising-edge clock
//   rst_n         in   1        asynchronous active-low reset
//   req_i         in   NUM_SRC  req_i[k]: source k has a beat available
//   req_last_i    in   NUM_SRC  req_last_i[k]: source k's current beat is its last
//   out_ready_i   in   1        downstream accepts the beat this cycle
//   sel_o         out  SEL_W    mux select, index of the granted / last-granted source
//   grant_o       out  NUM_SRC  one-hot grant, all-zero while idle
//   out_valid_o   out  1        beat valid on the mux output
//   out_last_o    out  1        valid beat is the last of its packet
//   timeout_err_o out  1        one-cycle pulse when the watchdog releases a grant

module mux9_rr_sel_arbiter #(
  parameter int NUM_SRC   = 9,
  parameter int SEL_W     = 4,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [NUM_SRC-1:0] req_last_i,
  input  logic               out_ready_i,
  output logic [SEL_W-1:0]   sel_o,
  output logic [NUM_SRC-1:0] grant_o,
  output logic               out_valid_o,
  output logic               out_last_o,
  output logic               timeout_err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic               timeout_q;

  logic [SEL_W-1:0]   win_idx_d;
  logic               win_found;
  logic [SEL_W:0]     cand;
  logic [SEL_W-1:0]   ptr_d;
  logic [CNT_W-1:0]   beat_cnt_d;
  logic               xfer;
  logic               cur_last;

  // Round-robin pick: walk the sources starting at the pointer, wrapping past
  // the top, and keep the first one that is requesting. The candidate index is
  // one bit wider so that ptr+i can be compared against NUM_SRC before wrapping.
  always_comb begin
    win_idx_d = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = {1'b0, ptr_q} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(NUM_SRC)) begin
        cand = cand - (SEL_W+1)'(NUM_SRC);
      end
      if (!win_found && req_i[cand[SEL_W-1:0]]) begin
        win_found = 1'b1;
        win_idx_d = cand[SEL_W-1:0];
      end
    end
  end

  // Handshake view of the current packet. A beat only counts when the granted
  // source is presenting data and the consumer takes it; the pointer for the
  // next arbitration always starts just after whoever finished last.
  always_comb begin
    cur_last   = req_last_i[sel_q];
    xfer       = (state_q == BUSY) && req_i[sel_q] && out_ready_i;
    beat_cnt_d = beat_cnt_q + CNT_W'(1);
    ptr_d      = (sel_q == SEL_W'(NUM_SRC - 1)) ? '0 : sel_q + SEL_W'(1);
  end

  // Packet FSM. IDLE registers a winner and moves to BUSY; BUSY holds the grant
  // until a transfer carries the last beat or the watchdog count is reached,
  // then always drops back to IDLE, which gives the guaranteed bubble between
  // packets. A last beat on the watchdog beat wins, so no error is flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      grant_q    <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            sel_q      <= win_idx_d;
            grant_q    <= NUM_SRC'(1) << win_idx_d;
            beat_cnt_q <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            if (cur_last || (beat_cnt_d == CNT_W'(MAX_BEATS))) begin
              state_q    <= IDLE;
              grant_q    <= '0;
              beat_cnt_q <= '0;
              ptr_q      <= ptr_d;
              timeout_q  <= !cur_last;
            end else begin
              beat_cnt_q <= beat_cnt_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Valid and last follow the granted source's live request lines so a source
  // that pauses mid-packet simply shows no valid beat while keeping its grant.
  always_comb begin
    sel_o         = sel_q;
    grant_o       = grant_q;
    out_valid_o   = (state_q == BUSY) && req_i[sel_q];
    out_last_o    = out_valid_o && cur_last;
    timeout_err_o = timeout_q;
  end

endmodule

// File: tb/tb_mux9_rr_sel_arbiter.sv
// tb_mux9_rr_sel_arbiter
//   Self-checking bench for mux9_rr_sel_arbiter. A behavioural model tracks which
//   source owns the mux, the round-robin start point and the beat count, and
//   every cycle the DUT outputs are compared against it. Directed scenarios pin
//   known values (first grant, round-robin order, backpressure, watchdog, pointer
//   wrap, asynchronous reset), then a long randomized run follows.

module tb_mux9_rr_sel_arbiter;

  localparam int NUM_SRC   = 9;
  localparam int SEL_W     = 4;
  localparam int MAX_BEATS = 16;

  logic               clk;
  logic               rst_n;
  logic [NUM_SRC-1:0] req_i;
  logic [NUM_SRC-1:0] req_last_i;
  logic               out_ready_i;
  logic [SEL_W-1:0]   sel_o;
  logic [NUM_SRC-1:0] grant_o;
  logic               out_valid_o;
  logic               out_last_o;
  logic               timeout_err_o;

  int testsRun    = 0;
  int testsFailed = 0;

  bit mBusy;
  int mSel;
  int mPtr;
  int mCount;
  bit mTimeout;

  mux9_rr_sel_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .SEL_W    (SEL_W),
    .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .req_last_i   (req_last_i),
    .out_ready_i  (out_ready_i),
    .sel_o        (sel_o),
    .grant_o      (grant_o),
    .out_valid_o  (out_valid_o),
    .out_last_o   (out_last_o),
    .timeout_err_o(timeout_err_o)
  );

  // Free-running clock: rising edges at 5, 15, 25 ... so inputs change and
  // outputs are sampled around the falling edge, well away from the active one.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports name, actual and required on a miss.
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model forgets any packet in flight and restarts arbitration at source 0.
  task automatic modelReset();
    mBusy    = 1'b0;
    mSel     = 0;
    mPtr     = 0;
    mCount   = 0;
    mTimeout = 1'b0;
  endtask

  // Compare every DUT output with what the model says this cycle should show.
  task automatic checkOutput();
    logic [NUM_SRC-1:0] expGrant;
    logic               expValid;
    logic               expLast;
    expGrant = mBusy ? (NUM_SRC'(1) << mSel) : '0;
    expValid = mBusy && req_i[mSel];
    expLast  = expValid && req_last_i[mSel];
    checkVal("model_grant",   32'(grant_o),       32'(expGrant));
    checkVal("model_sel",     32'(sel_o),         32'(mSel));
    checkVal("model_valid",   32'(out_valid_o),   32'(expValid));
    checkVal("model_last",    32'(out_last_o),    32'(expLast));
    checkVal("model_timeout", 32'(timeout_err_o), 32'(mTimeout));
  endtask

  // Advance the model over one rising edge using this cycle's inputs:
  // an idle arbiter takes the first requester at or after the pointer; a busy
  // one counts accepted beats and lets go on a last beat or at MAX_BEATS.
  task automatic modelStep();
    bit xfer;
    bit finished;
    xfer     = mBusy && req_i[mSel] && out_ready_i;
    finished = 1'b0;
    mTimeout = 1'b0;
    if (!mBusy) begin
      if (req_i != '0) begin
        for (int k = 0; k < NUM_SRC; k++) begin
          int c;
          c = (mPtr + k) % NUM_SRC;
          if (req_i[c]) begin
            mSel = c;
            break;
          end
        end
        mBusy  = 1'b1;
        mCount = 0;
      end
    end else if (xfer) begin
      mCount++;
      if (req_last_i[mSel]) begin
        finished = 1'b1;
      end else if (mCount == MAX_BEATS) begin
        finished = 1'b1;
        mTimeout = 1'b1;
      end
    end
    if (finished) begin
      mBusy  = 1'b0;
      mCount = 0;
      mPtr   = (mSel + 1) % NUM_SRC;
    end
  endtask

  // Drive one cycle of inputs after the falling edge, check the outputs they
  // produce, then step the model across the coming rising edge.
  task automatic applyStimulus(input logic [NUM_SRC-1:0] r, input logic [NUM_SRC-1:0] l,
                               input logic rdy);
    @(negedge clk);
    req_i       = r;
    req_last_i  = l;
    out_ready_i = rdy;
    #2;
    checkOutput();
    modelStep();
  endtask

  // Pull reset low between edges and expect every output to clear at once,
  // then release on a falling edge so the release is clean.
  task automatic doAsyncReset();
    @(negedge clk);
    #3;
    rst_n       = 1'b0;
    req_i       = '0;
    req_last_i  = '0;
    out_ready_i = 1'b0;
    #1;
    checkVal("rst_grant",   32'(grant_o),       32'h0);
    checkVal("rst_sel",     32'(sel_o),         32'h0);
    checkVal("rst_valid",   32'(out_valid_o),   32'h0);
    checkVal("rst_last",    32'(out_last_o),    32'h0);
    checkVal("rst_timeout", 32'(timeout_err_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  // Directed scenarios first, each with a few hand-computed values, then a
  // randomized run where only the model is the reference.
  initial begin
    logic [NUM_SRC-1:0] rReq;
    logic [NUM_SRC-1:0] rLast;
    logic               rRdy;
    int                 lastMode;

    rst_n       = 1'b0;
    req_i       = '0;
    req_last_i  = '0;
    out_ready_i = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    #2;
    checkVal("init_grant",   32'(grant_o),       32'h0);
    checkVal("init_sel",     32'(sel_o),         32'h0);
    checkVal("init_valid",   32'(out_valid_o),   32'h0);
    checkVal("init_timeout", 32'(timeout_err_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single source, three-beat packet.
    applyStimulus(9'h001, 9'h000, 1'b1);
    checkVal("p3_idle_grant", 32'(grant_o), 32'h0);
    applyStimulus(9'h001, 9'h000, 1'b1);
    checkVal("p3_grant", 32'(grant_o), 32'h001);
    checkVal("p3_valid1", 32'(out_valid_o), 32'h1);
    applyStimulus(9'h001, 9'h000, 1'b1);
    checkVal("p3_last2", 32'(out_last_o), 32'h0);
    applyStimulus(9'h001, 9'h001, 1'b1);
    checkVal("p3_last3", 32'(out_last_o), 32'h1);
    applyStimulus(9'h000, 9'h000, 1'b1);
    checkVal("p3_release", 32'(grant_o), 32'h0);

    // All sources requesting single-beat packets: 0..8 then 0, bubble between.
    doAsyncReset();
    applyStimulus(9'h1FF, 9'h1FF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(9'h1FF, 9'h1FF, 1'b1);
      checkVal("rr_grant", 32'(grant_o), 32'(NUM_SRC'(1) << (k % NUM_SRC)));
      checkVal("rr_sel",   32'(sel_o),   32'(k % NUM_SRC));
      applyStimulus((k == 9) ? 9'h000 : 9'h1FF, 9'h1FF, 1'b1);
      checkVal("rr_bubble", 32'(grant_o), 32'h0);
    end

    // Backpressure on source 2 for five cycles mid-packet.
    applyStimulus(9'h004, 9'h000, 1'b1);
    applyStimulus(9'h004, 9'h000, 1'b1);
    checkVal("bp_grant", 32'(grant_o), 32'h004);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(9'h004, 9'h000, 1'b0);
      checkVal("bp_hold_grant", 32'(grant_o), 32'h004);
      checkVal("bp_hold_sel",   32'(sel_o),   32'h2);
    end
    applyStimulus(9'h004, 9'h000, 1'b1);
    applyStimulus(9'h004, 9'h004, 1'b1);
    checkVal("bp_last", 32'(out_last_o), 32'h1);

    // Watchdog: source 4 never ends its packet while source 5 waits.
    applyStimulus(9'h030, 9'h000, 1'b1);
    checkVal("wd_bubble", 32'(grant_o), 32'h0);
    for (int k = 0; k < MAX_BEATS; k++) begin
      applyStimulus(9'h030, 9'h000, 1'b1);
      checkVal("wd_grant", 32'(grant_o), 32'h010);
    end
    applyStimulus(9'h030, 9'h000, 1'b1);
    checkVal("wd_pulse", 32'(timeout_err_o), 32'h1);
    checkVal("wd_release", 32'(grant_o), 32'h0);
    applyStimulus(9'h030, 9'h020, 1'b1);
    checkVal("wd_next_grant", 32'(grant_o), 32'h020);
    checkVal("wd_pulse_end", 32'(timeout_err_o), 32'h0);

    // Pointer wrap: source 8 finishes, then source 0 beats source 8.
    applyStimulus(9'h100, 9'h100, 1'b1);
    applyStimulus(9'h100, 9'h100, 1'b1);
    checkVal("wrap_sel8", 32'(sel_o), 32'h8);
    applyStimulus(9'h101, 9'h101, 1'b1);
    applyStimulus(9'h101, 9'h101, 1'b1);
    checkVal("wrap_grant0", 32'(grant_o), 32'h001);

    // Reset in the middle of a packet, then the first grant goes to source 0.
    applyStimulus(9'h002, 9'h000, 1'b1);
    applyStimulus(9'h002, 9'h000, 1'b1);
    checkVal("mid_busy", 32'(grant_o), 32'h002);
    doAsyncReset();
    applyStimulus(9'h1FF, 9'h000, 1'b1);
    applyStimulus(9'h1FF, 9'h000, 1'b1);
    checkVal("post_rst_grant", 32'(grant_o), 32'h001);

    // Randomized traffic with changing last-beat density and occasional resets.
    lastMode = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) lastMode = $urandom_range(0, 2);
      if ($urandom_range(0, 599) == 0) doAsyncReset();
      rReq = NUM_SRC'($urandom) & NUM_SRC'($urandom);
      if ($urandom_range(0, 3) != 0) rReq = rReq | NUM_SRC'($urandom);
      case (lastMode)
        0:       rLast = '0;
        1:       rLast = NUM_SRC'($urandom) & NUM_SRC'($urandom);
        default: rLast = NUM_SRC'($urandom);
      endcase
      rRdy = ($urandom_range(0, 3) != 0);
      applyStimulus(rReq, rLast, rRdy);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
